// File: rtl/unary_adder_scheduler.sv
// Round-robin scheduler sharing one unary adder between NUM_REQ binary requesters.
// Optional result self-check (rsp_err output) is enabled by defining UNARY_SCHED_CHECK_EN.
module unary_adder_scheduler #(
  parameter int NUM_REQ       = 2,
  parameter int WIDTH         = 8,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ua,
  output logic                       ub,
  output logic [1:0]                 uready,
  input  logic                       uvalid,
  input  logic                       uy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH:0]             rsp_sum,
  output logic                       rsp_timeout,
  output logic                       busy
`ifdef UNARY_SCHED_CHECK_EN
  ,
  output logic                       rsp_err
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int IC_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              ptr_vld_q, ptr_vld_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0]  len_q, len_d, k_q, k_d, k_inc;
  logic [WIDTH:0]    ycnt_q, ycnt_d;
  logic [IC_W-1:0]   idle_q, idle_d;
  logic              seen_q, seen_d;
  logic              to_q, to_d;
  logic              ua_d, ub_d;
  logic [1:0]        uready_d;

  // Arbiter: first valid requester after the last grant. Until the first grant
  // after reset the search starts at requester 0.
  int                base;
  int                idx;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [WIDTH-1:0]  a_sel, b_sel, max_sel;

  always_comb begin
    base      = ptr_vld_q ? int'(ptr_q) : NUM_REQ - 1;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = (base + j) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
    if (gnt_found) gnt_oh[gnt_id] = 1'b1;
  end

  assign a_sel   = req_a[gnt_id*WIDTH +: WIDTH];
  assign b_sel   = req_b[gnt_id*WIDTH +: WIDTH];
  assign max_sel = (a_sel > b_sel) ? a_sel : b_sel;
  assign k_inc   = k_q + 1'b1;

  // NOTE: every signal written here gets a default first so no latch is inferred;
  // blocking assignments are correct in combinational logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ptr_vld_d = ptr_vld_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    len_d     = len_q;
    k_d       = k_q;
    ycnt_d    = ycnt_q;
    idle_d    = idle_q;
    seen_d    = seen_q;
    to_d      = to_q;
    ua_d      = 1'b0;
    ub_d      = 1'b0;
    uready_d  = 2'b00;
    req_ready = '0;

    if ((state_q == S_STREAM || state_q == S_DRAIN) && uvalid && uy && !(&ycnt_q))
      ycnt_d = ycnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        req_ready = gnt_oh;
        if (gnt_found) begin
          op_a_d    = a_sel;
          op_b_d    = b_sel;
          id_d      = gnt_id;
          ptr_d     = gnt_id;
          ptr_vld_d = 1'b1;
          len_d     = max_sel;
          k_d       = '0;
          ycnt_d    = '0;
          idle_d    = '0;
          seen_d    = 1'b0;
          to_d      = 1'b0;
          if (max_sel != '0) begin
            state_d  = S_STREAM;
            ua_d     = (a_sel != '0);
            ub_d     = (b_sel != '0);
            uready_d = 2'b11;
          end else begin
            state_d  = S_DRAIN;
          end
        end
      end
      S_STREAM: begin
        if (uvalid) seen_d = 1'b1;
        if (k_q == len_q - 1'b1) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_inc;
          ua_d     = (k_inc < op_a_q);
          ub_d     = (k_inc < op_b_q);
          uready_d = 2'b11;
        end
      end
      S_DRAIN: begin
        if (uvalid) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = S_RESP;
          to_d    = 1'b0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IC_W'(DRAIN_TIMEOUT - 1)) begin
            state_d = S_RESP;
            to_d    = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      ptr_vld_q <= 1'b0;
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      ycnt_q    <= '0;
      idle_q    <= '0;
      seen_q    <= 1'b0;
      to_q      <= 1'b0;
      ua        <= 1'b0;
      ub        <= 1'b0;
      uready    <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
      id_q      <= id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      len_q     <= len_d;
      k_q       <= k_d;
      ycnt_q    <= ycnt_d;
      idle_q    <= idle_d;
      seen_q    <= seen_d;
      to_q      <= to_d;
      ua        <= ua_d;
      ub        <= ub_d;
      uready    <= uready_d;
    end
  end

  // The count is frozen outside STREAM/DRAIN, so it doubles as the held result.
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = id_q;
  assign rsp_sum     = ycnt_q;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != S_IDLE);

`ifdef UNARY_SCHED_CHECK_EN
  logic err_d;

  always_comb begin
    err_d = rsp_err;
    if (state_q == S_IDLE && gnt_found)
      err_d = 1'b0;
    else if (state_q != S_RESP && state_d == S_RESP)
      err_d = (ycnt_d != ({1'b0, op_a_q} + {1'b0, op_b_q})) || to_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsp_err <= 1'b0;
    else        rsp_err <= err_d;
  end
`endif

endmodule
